// File: rtl/lzd_denorm.sv
// Two-stage denormalizer: restores a fixed-point value from a normalized
// mantissa and its leading-zero count by a logical right shift. It also reports
// any 1-bits lost off the bottom (sticky), and counts lossy output transfers.
module lzd_denorm #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned CW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mant,
    input  logic [CW:0]      in_lzc,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_sticky,
    output logic [15:0]      lost_cnt,
    input  logic             cnt_clr
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_mant;
    logic [CW:0]      s1_lzc;
    logic             s1_zero;

    logic s1_en;
    logic s2_en;

    // Both stages advance together, so in_ready follows out_ready combinationally.
    assign s2_en    = ~out_valid | out_ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign in_ready = s1_en;

    // Logarithmic shifter: level g shifts by 2**g and collects the bits it drops.
    logic [WIDTH-1:0] lvl [CW+1];
    logic [CW:0]      stk;

    assign lvl[0] = s1_mant;
    assign stk[0] = 1'b0;

    for (genvar g = 0; g < CW; g++) begin : g_shift
        localparam int unsigned SH = 2 ** g;
        localparam logic [WIDTH-1:0] MASK = ~({WIDTH{1'b1}} << SH);
        assign lvl[g+1] = s1_lzc[g] ? (lvl[g] >> SH) : lvl[g];
        assign stk[g+1] = stk[g] | (s1_lzc[g] & (|(lvl[g] & MASK)));
    end

    logic [WIDTH-1:0] s2_data_d;
    logic             s2_sticky_d;

    // Select the S2 result: zero source wins, then overshift, then normal shift.
    always_comb begin
        s2_data_d   = lvl[CW];
        s2_sticky_d = stk[CW];
        if (s1_zero) begin
            s2_data_d   = '0;
            s2_sticky_d = 1'b0;
        end else if (s1_lzc[CW]) begin
            // Count >= WIDTH: every mantissa bit is shifted out.
            s2_data_d   = '0;
            s2_sticky_d = |s1_mant;
        end
    end

    // Stage 1: capture the input transaction unmodified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_lzc   <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1_mant  <= in_mant;
            s1_lzc   <= in_lzc;
            s1_zero  <= in_zero;
        end
    end

    // Stage 2: register the shifted result; hold it while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_sticky <= 1'b0;
        end else if (s2_en) begin
            out_valid  <= s1_valid;
            out_data   <= s2_data_d;
            out_zero   <= (s2_data_d == '0);
            out_sticky <= s2_sticky_d;
        end
    end

    // Saturating count of lossy output transfers; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
        end else if (cnt_clr) begin
            lost_cnt <= '0;
        end else if (out_valid && out_ready && out_sticky && (lost_cnt != 16'hFFFF)) begin
            lost_cnt <= lost_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lzd_denorm.sv
// Scoreboard bench for lzd_denorm: accepted inputs push a model result, a
// monitor compares every presented output and tracks lost_cnt and in_ready.
module tb_lzd_denorm;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         zero;
        logic         sticky;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_mant = '0;
    logic [4:0]   in_lzc = '0;
    logic         in_zero = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_zero;
    logic         out_sticky;
    logic [15:0]  lost_cnt;
    logic         cnt_clr = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [15:0] exp_cnt = '0;

    lzd_denorm #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_lzc     (in_lzc),
        .in_zero    (in_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_sticky (out_sticky),
        .lost_cnt   (lost_cnt),
        .cnt_clr    (cnt_clr)
    );

    always #5 clk = ~clk;

    // Reference: value = mant / 2^lzc, sticky = nonzero remainder.
    function automatic exp_t model(input logic [W-1:0] m, input int lzc, input logic z);
        exp_t r;
        int   mi;
        mi = int'(m);
        if (z) begin
            r.data   = '0;
            r.sticky = 1'b0;
        end else if (lzc >= W) begin
            r.data   = '0;
            r.sticky = (mi != 0);
        end else begin
            r.data   = W'(mi / (1 << lzc));
            r.sticky = ((mi % (1 << lzc)) != 0);
        end
        r.zero = (r.data == '0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare on the falling edge, away from the active edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic xs;
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
            chk("lost_cnt", 32'(lost_cnt), 32'(exp_cnt));
            xs = 1'b0;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = q[0];
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_zero", 32'(out_zero), 32'(e.zero));
                    chk("out_sticky", 32'(out_sticky), 32'(e.sticky));
                    if (out_ready) begin
                        xs = e.sticky;
                        void'(q.pop_front());
                    end
                end
            end
            if (cnt_clr) exp_cnt = '0;
            else if (xs && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (in_valid && in_ready) q.push_back(model(in_mant, int'(in_lzc), in_zero));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] m, input int lzc, input logic z);
        int   n;
        logic acc;
        in_valid = 1'b1;
        in_mant  = m;
        in_lzc   = 5'(lzc);
        in_zero  = z;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("send_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        step();
    endtask

    // Sends one item into an empty pipe and measures cycles to out_valid.
    task automatic send_lat(input logic [W-1:0] m, input int lzc);
        int n;
        out_ready = 1'b1;
        send(m, lzc, 1'b0);
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd2);
        drain();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        logic        pat [10];
        logic [15:0] vals [6];
        int          k;
        int          n;
        logic        acc;

        pat  = '{1, 0, 0, 0, 1, 1, 0, 1, 1, 1};
        vals = '{16'h8421, 16'hF00F, 16'h1234, 16'hABCD, 16'h0F0F, 16'h8000};

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_sticky", 32'(out_sticky), 32'd0);
        chk("rst_lost_cnt", 32'(lost_cnt), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Basic shift with latency
        send_lat(16'h8000, 2);

        // Sticky and counter
        send(16'hC003, 1, 1'b0);
        drain();
        chk("lost_after_sticky", 32'(lost_cnt), 32'd1);
        out_ready = 1'b0;
        send(16'hC003, 1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        cnt_clr   = 1'b1;
        out_ready = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_priority", 32'(lost_cnt), 32'd0);
        drain();

        // Overshift and zero flag
        send(16'h8001, 16, 1'b0);
        send(16'h8001, 31, 1'b0);
        send(16'h0000, 20, 1'b0);
        send(16'hFFFF, 0, 1'b1);
        send(16'hFFFF, 15, 1'b0);
        send(16'h1234, 0, 1'b0);
        drain();

        // Back-pressure stream of 6 items
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 6; cyc++) begin
            out_ready = (cyc < 10) ? pat[cyc] : 1'b1;
            in_valid  = 1'b1;
            in_mant   = vals[k];
            in_lzc    = 5'(k * 3);
            in_zero   = 1'b0;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(k), 32'd6);
        for (int cyc = 0; cyc < 4; cyc++) begin
            out_ready = (cyc % 2 == 1);
            step();
        end
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            in_mant   = W'($urandom);
            if ($urandom % 2 == 0) in_mant[W-1] = 1'b1;
            in_lzc    = 5'($urandom_range(0, 31));
            in_zero   = ($urandom % 10) == 0;
            out_ready = ($urandom % 10) < 7;
            cnt_clr   = ($urandom % 40) == 0;
            step();
        end
        cnt_clr = 1'b0;
        drain();

        // Reset mid-flight with lost_cnt = 5
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) send(16'h8001, 1, 1'b0);
        drain();
        chk("lost_before_reset", 32'(lost_cnt), 32'd5);
        out_ready = 1'b0;
        send(16'h4000, 1, 1'b0);
        send(16'h2000, 1, 1'b0);
        chk("inflight_before_reset", 32'(q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_lost_cnt", 32'(lost_cnt), 32'd0);
        q.delete();
        exp_cnt   = '0;
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_out_valid_after", 32'(out_valid), 32'd0);
        send_lat(16'hA5A5, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lzd_denorm.md
# lzd_denorm

Pipelined denormalizer: the inverse of the leading-zero detector in the AWGN datapath. It takes a normalized mantissa plus its leading-zero count and reconstructs the fixed-point value by a logical right shift. It also reports the bits lost in the shift. It sits at the output of the log/sqrt function units, returning normalized intermediates to fixed-point before the Box-Muller multiply stage. It uses a two-stage valid/ready pipeline and keeps a saturating count of lossy transfers.

## Interface
Parameters:
- WIDTH, 16, mantissa/data width; power of two, at least 4.
- CW, $clog2(WIDTH) (localparam, derived), shift-count width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept input this cycle.
- in_mant  in  WIDTH  normalized mantissa; MSB normally 1, but this is not checked.
- in_lzc  in  CW+1  leading-zero count to restore, 0..2^(CW+1)-1.
- in_zero  in  1  source value was all-zero (inverted LZD valid).
- out_valid  out  1  output transaction present.
- out_ready  in  1  downstream accepts output.
- out_data  out  WIDTH  denormalized value.
- out_zero  out  1  out_data == 0.
- out_sticky  out  1  OR of all 1-bits shifted out.
- lost_cnt  out  16  saturating count of output transfers with out_sticky=1.
- cnt_clr  in  1  synchronous clear of lost_cnt.

## Operation
- Input transfer occurs on an edge where in_valid && in_ready; output transfer occurs on an edge where out_valid && out_ready.
- Stage 1 (S1) registers in_mant, in_lzc and in_zero unmodified, plus s1_valid.
- Stage 2 (S2) computes the shift from the S1 registers and registers out_data, out_zero, out_sticky and out_valid.
- Shift rules:
  - in_zero=1: out_data=0, out_sticky=0, out_zero=1, regardless of in_mant and in_lzc.
  - in_lzc >= WIDTH: out_data=0, out_sticky=|in_mant, out_zero=1.
  - Otherwise: out_data = in_mant >> in_lzc (zero fill), and out_sticky = OR of in_mant[in_lzc-1:0] (0 when in_lzc=0).
  - out_zero = (out_data == 0) in all cases.
- The shifter is logarithmic: CW mux levels, all inside S2's combinational path.
- Flow control:
  - s2_en = ~out_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en.
  - in_ready is combinational from out_ready; this is accepted and required for full throughput.
- S2 loads when s2_en. Its valid becomes s1_valid. When s2_en is low, S2 holds all outputs stable.
- S1 loads when s1_en. Its valid becomes in_valid && in_ready.
- Ordering is strict FIFO. No transaction is dropped or duplicated. Capacity is 2 in flight.
- lost_cnt:
  - Increments by 1 on each output transfer with out_sticky=1.
  - Saturates at 16'hFFFF.
  - cnt_clr=1 forces it to 0 on the next edge, and takes priority over a same-cycle increment.

## Timing
- Reset (rst_n=0, asynchronous): s1_valid=0, out_valid=0, out_data=0, out_zero=0, out_sticky=0, lost_cnt=0. All S1 data registers are 0.
- in_ready=1 whenever both stages are empty, including during reset. Its value while reset is asserted is don't-care to upstream.
- Reset asserted mid-operation discards all in-flight transactions immediately (asynchronous), with no output transfer.
- Latency: input accepted at the end of cycle c gives out_valid=1 in cycle c+2 when unstalled.
- Throughput: 1 transaction/cycle with out_ready held high.
- Back-pressure:
  - With out_ready=0, at most 2 further transfers are accepted; in_ready then drops in the cycle both stages hold data.
  - in_ready rises in the same cycle out_ready rises, since both stages advance together.
- Simultaneous output transfer and S1 load: S2 takes S1's contents, and S1 takes the new input, on the same edge.
- While stalled, out_data, out_zero and out_sticky are held constant.

## Test plan
- Basic shift: WIDTH=16, in_mant=16'h8000, in_lzc=2, out_ready=1. Required: out_data=16'h2000, out_sticky=0, out_zero=0, out_valid exactly 2 cycles after acceptance.
- Sticky: in_mant=16'hC003, in_lzc=1. Required: out_data=16'h6001, out_sticky=1, lost_cnt 0→1. Then cnt_clr=1 in the same cycle as a sticky transfer: lost_cnt=0.
- Overshift: in_mant=16'h8001 with in_lzc=16 and with in_lzc=31. Required each time: out_data=0, out_zero=1, out_sticky=1. With in_mant=16'h0000, in_lzc=20: out_sticky=0.
- Zero flag: in_zero=1, in_mant=16'hFFFF, in_lzc=0. Required: out_data=0, out_zero=1, out_sticky=0, lost_cnt unchanged.
- Back-pressure: stream 6 distinct inputs with in_valid=1 and out_ready pattern 1,0,0,0,1,1,0,1,1,1. Required: in_ready low only while both stages are full, all 6 results in order, none lost or duplicated, out_data stable while stalled.
- Reset mid-flight: 2 transactions in flight and lost_cnt=5, pulse rst_n low between edges. Required: out_valid=0 and lost_cnt=0 immediately. After release, in_ready=1, and a new input yields a correct result at c+2.
